// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-requester data memory bus bundle with arbiter/requester modports
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req, m0_wren, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_wren, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          cpu_stall;

  modport slave (
    input  m0_req, m0_wren, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_wren, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_wren, mem_addr, mem_wdata,
    input  mem_rdata,
    output cpu_stall
  );

  modport master (
    output m0_req, m0_wren, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_wren, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_wren, mem_addr, mem_wdata,
    output mem_rdata,
    input  cpu_stall
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin/locking arbiter for the single-port data memory
// Optional DMEM_ARB_PRIO_EN: m0 always wins ties when no requester owns the bus.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  logic [1:0]    owner_q, owner_d;
  logic [3:0]    hold_cnt_q, hold_cnt_d;
  logic          last_q, last_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_who_q, rd_who_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          win0, win1, forced, tie_m0;

  always_comb begin
`ifdef DMEM_ARB_PRIO_EN
    tie_m0 = 1'b1;
`else
    tie_m0 = last_q;
`endif
    forced = ((owner_q == OWN0) && bus.m1_req && (hold_cnt_q >= HOLD_LIM)) ||
             ((owner_q == OWN1) && bus.m0_req && (hold_cnt_q >= HOLD_LIM));
    win0 = 1'b0;
    win1 = 1'b0;
    // reset gates every grant so nothing reaches memory while held in reset
    if (reset) begin
      if (forced) begin
        win0 = (owner_q == OWN1);
        win1 = (owner_q == OWN0);
      end else if ((owner_q == OWN0) && bus.m0_req) begin
        win0 = 1'b1;
      end else if ((owner_q == OWN1) && bus.m1_req) begin
        win1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        win0 = tie_m0;
        win1 = !tie_m0;
      end else begin
        win0 = bus.m0_req;
        win1 = bus.m1_req;
      end
    end
  end

  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_valid_d = 1'b0;
    rd_who_d   = 1'b0;
    if (win0 || win1) begin
      last_d     = win1;
      addr_d     = win1 ? bus.m1_addr  : bus.m0_addr;
      wdata_d    = win1 ? bus.m1_wdata : bus.m0_wdata;
      rd_valid_d = win1 ? !bus.m1_wren : !bus.m0_wren;
      rd_who_d   = win1;
      if ((win0 && owner_q == OWN0) || (win1 && owner_q == OWN1)) begin
        if (win1 ? bus.m1_lock : bus.m0_lock) begin
          hold_cnt_d = (hold_cnt_q == 4'hF) ? hold_cnt_q : hold_cnt_q + 4'd1;
        end else begin
          owner_d    = IDLE;
          hold_cnt_d = 4'd0;
        end
      end else if (win1 ? bus.m1_lock : bus.m0_lock) begin
        // the grant that takes ownership counts as the first held cycle
        owner_d    = win1 ? OWN1 : OWN0;
        hold_cnt_d = 4'd1;
      end else begin
        owner_d    = IDLE;
        hold_cnt_d = 4'd0;
      end
    end else if (owner_q != IDLE) begin
      owner_d    = IDLE;
      hold_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= IDLE;
      hold_cnt_q <= 4'd0;
      last_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_who_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      rd_valid_q <= rd_valid_d;
      rd_who_q   <= rd_who_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.m0_gnt    = win0;
  assign bus.m1_gnt    = win1;
  assign bus.mem_wren  = (win0 && bus.m0_wren) || (win1 && bus.m1_wren);
  assign bus.mem_addr  = (win0 || win1) ? addr_d  : addr_q;
  assign bus.mem_wdata = (win0 || win1) ? wdata_d : wdata_q;
  assign bus.m0_rvalid = rd_valid_q && !rd_who_q;
  assign bus.m1_rvalid = rd_valid_q && rd_who_q;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
  assign bus.cpu_stall = bus.m0_req && !win0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mem [0:63];
  logic [31:0] rdata_q;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
  dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scdatamem stand-in: synchronous write, read data one cycle after address
  always @(posedge clk) begin
    if (bus.mem_wren) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr[7:2]];
  end
  assign bus.mem_rdata = rdata_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_wren = 0; bus.m0_lock = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_wren = 0; bus.m1_lock = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    #2 reset = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    bus.m0_req = 1;
    bus.m1_req = 1;
    bus.m1_wren = 1;
    bus.m1_addr = 32'h20;
    #3;
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wren} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 00000", {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.mem_wren});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h/%h want 0/0", bus.m0_rdata, bus.m1_rdata);
    end
    checks++;
    if (bus.cpu_stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall got %b want 1", bus.cpu_stall);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    bus.m0_req = 1; bus.m0_wren = 1; bus.m0_addr = 32'h10; bus.m0_wdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if (bus.m0_gnt !== 1 || bus.mem_wren !== 1 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wr_issue got gnt=%b wren=%b addr=%h wdata=%h want 1 1 10 a5a5a5a5",
                         bus.m0_gnt, bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    idle_inputs();
    bus.m1_req = 1; bus.m1_addr = 32'h10;
    #1;
    checks++;
    if (bus.m1_gnt !== 1 || bus.mem_wren !== 0 || bus.m0_rvalid !== 0) begin
      errors++; $display("FAIL rd_issue got gnt=%b wren=%b m0_rvalid=%b want 1 0 0", bus.m1_gnt, bus.mem_wren, bus.m0_rvalid);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.m1_rvalid !== 1 || bus.m1_rdata !== 32'hA5A5A5A5 || bus.m0_rvalid !== 0 || bus.m0_rdata !== 0) begin
      errors++; $display("FAIL rd_return got m1v=%b m1d=%h m0v=%b m0d=%h want 1 a5a5a5a5 0 0",
                         bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid, bus.m0_rdata);
    end
    checks++;
    if (bus.mem_wren !== 0 || bus.mem_addr !== 32'h10) begin
      errors++; $display("FAIL idle_hold got wren=%b addr=%h want 0 10", bus.mem_wren, bus.mem_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [0:2];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.m0_req = 1; bus.m0_wren = 1; bus.m0_addr = 32'(i * 4); bus.m0_wdata = vals[i];
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.m0_req = 1; bus.m0_wren = 0; bus.m0_addr = 32'(i * 4);
      end else begin
        idle_inputs();
      end
      #1;
      if (i > 0) begin
        checks++;
        if (bus.m0_rvalid !== 1 || bus.m0_rdata !== vals[i-1] || bus.m1_rvalid !== 0) begin
          errors++; $display("FAIL b2b_rd%0d got v=%b d=%h m1v=%b want 1 %h 0", i-1, bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, vals[i-1]);
        end
      end
      tick();
    end
    checks++;
    if (bus.m0_rvalid !== 0) begin
      errors++; $display("FAIL b2b_end got rvalid=%b want 0", bus.m0_rvalid);
    end
  endtask

  task automatic test_arbitration();
    logic exp0;
    do_reset();
    bus.m0_req = 1; bus.m1_req = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef DMEM_ARB_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2 == 0);
`endif
      checks++;
      if (bus.m0_gnt !== exp0 || bus.m1_gnt !== !exp0 || bus.cpu_stall !== !exp0) begin
        errors++; $display("FAIL arb_cyc%0d got g0=%b g1=%b stall=%b want %b %b %b",
                           i, bus.m0_gnt, bus.m1_gnt, bus.cpu_stall, exp0, !exp0, !exp0);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.m0_req = 1; bus.m0_addr = 32'h44;
      end
      #1;
      checks++;
      if (bus.m1_gnt !== (i < 4) || bus.m0_gnt !== (i == 4)) begin
        errors++; $display("FAIL lock_cyc%0d got g0=%b g1=%b want %b %b", i, bus.m0_gnt, bus.m1_gnt, i == 4, i < 4);
      end
      tick();
    end
    checks++;
    if (dut.hold_cnt_q !== 4'd0) begin
      errors++; $display("FAIL lock_hold got %0d want 0", dut.hold_cnt_q);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.m0_req = 1; bus.m1_req = 1;
    #1;
    bus.m1_req = 0;
    tick();
    bus.m0_req = 0;
    tick();
    bus.m0_req = 1; bus.m1_req = 1;
    #1;
    checks++;
    if (bus.m0_gnt !== 0 || bus.m1_gnt !== 1) begin
      errors++; $display("FAIL drop_rr got g0=%b g1=%b want 0 1", bus.m0_gnt, bus.m1_gnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bus.m0_req = 1; bus.m0_addr = 32'h10;
    tick();
    idle_inputs();
    #1 reset = 0;
    #1;
    checks++;
    if (bus.m0_rvalid !== 0 || bus.m0_rdata !== 0 || bus.mem_wren !== 0 || bus.mem_addr !== 0) begin
      errors++; $display("FAIL midrd_rst got v=%b d=%h wren=%b addr=%h want 0 0 0 0",
                         bus.m0_rvalid, bus.m0_rdata, bus.mem_wren, bus.mem_addr);
    end
    tick();
    #2 reset = 1;
    tick();
    checks++;
    if (bus.m0_rvalid !== 0) begin
      errors++; $display("FAIL midrd_after got rvalid=%b want 0", bus.m0_rvalid);
    end
    bus.m0_req = 1; bus.m1_req = 1;
    #1;
    checks++;
    if (bus.m0_gnt !== 1 || bus.m1_gnt !== 0) begin
      errors++; $display("FAIL midrd_tie got g0=%b g1=%b want 1 0", bus.m0_gnt, bus.m1_gnt);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 0;
    idle_inputs();
    #2;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_arbitration();
    test_lock();
    test_req_drop();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
